tx_ingress_ctrl: RTL and testbench

//   Upstream feeder for the TX main FIFO. Accepts 6-bit words from a source over a valid/ready

---
 rtl/tx_ingress_ctrl.sv | 93 +++++++++
 tb/tb_tx_ingress_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tx_ingress_ctrl.sv
// Skid buffer between a valid/ready source and the TX main FIFO push port.
// Drains one word per cycle while the main FIFO is not pausing, and counts delivered words.
module tx_ingress_ctrl #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned BUF_DEPTH  = 4,
  parameter int unsigned PTR_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  SRC_VALID,
  input  logic [DATA_WIDTH-1:0] SRC_DATA,
  output logic                  SRC_READY,
  input  logic                  FLUSH,
  input  logic                  MAIN_PAUSE,
  output logic                  PUSH_MAIN,
  output logic [DATA_WIDTH-1:0] DATA_IN_TX,
  output logic                  BUF_EMPTY,
  output logic [CNT_WIDTH-1:0]  PUSH_COUNT
);

  localparam int unsigned CW = PTR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem [BUF_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_d;
  logic                   accept, drain;

  // Ready looks only at the registered count; a same-cycle drain does not open a slot.
  assign SRC_READY = count < CW'(BUF_DEPTH);
  assign BUF_EMPTY = count == '0;
  assign accept    = SRC_VALID & SRC_READY & ~FLUSH;
  assign drain     = (state_q != IDLE) & ~MAIN_PAUSE & ~FLUSH;

  always_comb begin
    count_d = count;
    if (FLUSH)                count_d = '0;
    else if (accept & ~drain) count_d = count + CW'(1);
    else if (drain & ~accept) count_d = count - CW'(1);
  end

  // Next state tracks occupancy and the pause level seen at this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = MAIN_PAUSE ? HOLD : SEND;
      SEND, HOLD: begin
        if (count_d == '0)   state_d = IDLE;
        else if (MAIN_PAUSE) state_d = HOLD;
        else                 state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
    if (FLUSH) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      PUSH_MAIN  <= 1'b0;
      DATA_IN_TX <= '0;
      PUSH_COUNT <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      if (FLUSH) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        PUSH_MAIN <= 1'b0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        PUSH_MAIN <= drain;
        if (drain) begin
          DATA_IN_TX <= mem[rd_ptr];
          rd_ptr     <= rd_ptr + PTR_WIDTH'(1);
          PUSH_COUNT <= PUSH_COUNT + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= SRC_DATA;
  end

endmodule

// File: tb/tb_tx_ingress_ctrl.sv
// Bench for tx_ingress_ctrl: directed vector table, reset-mid-push sequence,
// and randomized traffic against a queue-based reference model.
module tb_tx_ingress_ctrl;

  logic       clk;
  logic       RESET;
  logic       SRC_VALID;
  logic [5:0] SRC_DATA;
  logic       SRC_READY;
  logic       FLUSH;
  logic       MAIN_PAUSE;
  logic       PUSH_MAIN;
  logic [5:0] DATA_IN_TX;
  logic       BUF_EMPTY;
  logic [7:0] PUSH_COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  tx_ingress_ctrl dut (
    .clk        (clk),
    .RESET      (RESET),
    .SRC_VALID  (SRC_VALID),
    .SRC_DATA   (SRC_DATA),
    .SRC_READY  (SRC_READY),
    .FLUSH      (FLUSH),
    .MAIN_PAUSE (MAIN_PAUSE),
    .PUSH_MAIN  (PUSH_MAIN),
    .DATA_IN_TX (DATA_IN_TX),
    .BUF_EMPTY  (BUF_EMPTY),
    .PUSH_COUNT (PUSH_COUNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [5:0] d;
    logic       p;
    logic       f;
    logic       rdy;
    logic       push;
    logic [5:0] dat;
    logic       emp;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [5:0] d, logic p, logic f,
                              logic rdy, logic push, logic [5:0] dat,
                              logic emp, logic [7:0] cnt);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.f = f;
    r.rdy = rdy; r.push = push; r.dat = dat; r.emp = emp; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic push,
                           input logic [5:0] dat, input logic emp, input logic [7:0] cnt);
    chk({tag, "_ready"}, 32'(SRC_READY),  32'(rdy));
    chk({tag, "_push"},  32'(PUSH_MAIN),  32'(push));
    chk({tag, "_data"},  32'(DATA_IN_TX), 32'(dat));
    chk({tag, "_empty"}, 32'(BUF_EMPTY),  32'(emp));
    chk({tag, "_count"}, 32'(PUSH_COUNT), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [5:0] mq[$];
  int         mcnt;
  logic [5:0] mdata;

  initial begin
    RESET = 1'b1; SRC_VALID = 1'b0; SRC_DATA = '0; FLUSH = 1'b0; MAIN_PAUSE = 1'b0;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
    check_all("reset", 1'b1, 1'b0, 6'h00, 1'b1, 8'd0);

    //        v  d      p  f    rdy push dat   emp cnt
    tbl.push_back(mk(1, 6'h0A, 0, 0,   1, 0, 6'h00, 0, 8'd0));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h0A, 1, 8'd1));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 0, 6'h0A, 1, 8'd1));
    tbl.push_back(mk(1, 6'h3E, 0, 0,   1, 0, 6'h0A, 0, 8'd1));
    tbl.push_back(mk(1, 6'h0F, 0, 0,   1, 1, 6'h3E, 0, 8'd2));
    tbl.push_back(mk(1, 6'h1E, 0, 0,   1, 1, 6'h0F, 0, 8'd3));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h1E, 1, 8'd4));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 0, 6'h1E, 1, 8'd4));
    tbl.push_back(mk(1, 6'h01, 1, 0,   1, 0, 6'h1E, 0, 8'd4));
    tbl.push_back(mk(1, 6'h02, 1, 0,   1, 0, 6'h1E, 0, 8'd4));
    tbl.push_back(mk(1, 6'h03, 1, 0,   1, 0, 6'h1E, 0, 8'd4));
    tbl.push_back(mk(1, 6'h04, 1, 0,   0, 0, 6'h1E, 0, 8'd4));
    tbl.push_back(mk(1, 6'h05, 1, 0,   0, 0, 6'h1E, 0, 8'd4));
    tbl.push_back(mk(1, 6'h05, 0, 0,   1, 1, 6'h01, 0, 8'd5));
    tbl.push_back(mk(1, 6'h05, 0, 0,   1, 1, 6'h02, 0, 8'd6));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h03, 0, 8'd7));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h04, 0, 8'd8));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h05, 1, 8'd9));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 0, 6'h05, 1, 8'd9));
    tbl.push_back(mk(1, 6'h10, 1, 0,   1, 0, 6'h05, 0, 8'd9));
    tbl.push_back(mk(1, 6'h11, 1, 0,   1, 0, 6'h05, 0, 8'd9));
    tbl.push_back(mk(1, 6'h12, 1, 0,   1, 0, 6'h05, 0, 8'd9));
    tbl.push_back(mk(1, 6'h13, 1, 0,   0, 0, 6'h05, 0, 8'd9));
    tbl.push_back(mk(1, 6'h14, 0, 0,   1, 1, 6'h10, 0, 8'd10));
    tbl.push_back(mk(1, 6'h14, 0, 0,   1, 1, 6'h11, 0, 8'd11));
    tbl.push_back(mk(1, 6'h15, 0, 0,   1, 1, 6'h12, 0, 8'd12));
    tbl.push_back(mk(1, 6'h16, 0, 0,   1, 1, 6'h13, 0, 8'd13));
    tbl.push_back(mk(1, 6'h17, 0, 0,   1, 1, 6'h14, 0, 8'd14));
    tbl.push_back(mk(1, 6'h18, 0, 0,   1, 1, 6'h15, 0, 8'd15));
    tbl.push_back(mk(1, 6'h19, 0, 0,   1, 1, 6'h16, 0, 8'd16));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h17, 0, 8'd17));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h18, 0, 8'd18));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 1, 6'h19, 1, 8'd19));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 0, 6'h19, 1, 8'd19));
    tbl.push_back(mk(1, 6'h2A, 1, 0,   1, 0, 6'h19, 0, 8'd19));
    tbl.push_back(mk(1, 6'h2B, 1, 0,   1, 0, 6'h19, 0, 8'd19));
    tbl.push_back(mk(1, 6'h2C, 1, 1,   1, 0, 6'h19, 1, 8'd19));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 0, 6'h19, 1, 8'd19));
    tbl.push_back(mk(0, 6'h00, 0, 0,   1, 0, 6'h19, 1, 8'd19));

    foreach (tbl[i]) begin
      SRC_VALID = tbl[i].v; SRC_DATA = tbl[i].d; MAIN_PAUSE = tbl[i].p; FLUSH = tbl[i].f;
      step();
      check_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].push, tbl[i].dat, tbl[i].emp, tbl[i].cnt);
    end

    // Asynchronous reset while a push strobe is out
    SRC_VALID = 1'b1; SRC_DATA = 6'h2D; MAIN_PAUSE = 1'b0; FLUSH = 1'b0;
    step();
    SRC_VALID = 1'b0;
    step();
    chk("pre_reset_push", 32'(PUSH_MAIN), 32'(1));
    chk("pre_reset_data", 32'(DATA_IN_TX), 32'(6'h2D));
    #1 RESET = 1'b1;
    #1;
    chk("async_reset_push",  32'(PUSH_MAIN),  32'(0));
    chk("async_reset_count", 32'(PUSH_COUNT), 32'(0));
    chk("async_reset_empty", 32'(BUF_EMPTY),  32'(1));
    chk("async_reset_data",  32'(DATA_IN_TX), 32'(0));
    step();
    RESET = 1'b0;

    // Randomized traffic against the queue model
    mq.delete(); mcnt = 0; mdata = '0;
    for (int c = 0; c < 3000; c++) begin
      logic v, p, f, rdy_before, exp_push;
      logic [5:0] d;
      v = 1'($urandom_range(0, 3) != 0);
      d = 6'($urandom);
      p = 1'($urandom_range(0, 2) == 0);
      f = 1'($urandom_range(0, 39) == 0);
      SRC_VALID = v; SRC_DATA = d; MAIN_PAUSE = p; FLUSH = f;
      rdy_before = mq.size() < 4;
      exp_push = 1'b0;
      if (f) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && !p) begin
          mdata = mq.pop_front();
          exp_push = 1'b1;
          mcnt++;
        end
        if (v && rdy_before) mq.push_back(d);
      end
      step();
      check_all($sformatf("rnd%0d", c), 1'(mq.size() < 4), exp_push, mdata,
                1'(mq.size() == 0), 8'(mcnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
